mem_lsu: RTL

//  MEM-stage load/store unit: consumes the EX/MEM pipeline register outputs and performs at most
//  one data-memory access per instruction over a valid/ready request/response bus.

---
 rtl/mem_lsu_pkg.sv | 36 +++
 rtl/mem_lsu_align.sv | 47 ++++
 rtl/mem_lsu.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: FSM states, funct3 access codes
// and the byte-strobe masks for each access size.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // funct3[1:0] is the log2 byte size, funct3[2] selects zero extension
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;
    localparam logic [2:0] F3_BAD = 3'd7;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return MASK_B;
            2'd1:    return MASK_H;
            2'd2:    return MASK_W;
            default: return MASK_D;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational alignment datapath: misalignment check, store strobe/data lane shift,
// and load byte extraction with sign/zero extension.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic [2:0]  i_st_off,
    input  logic [63:0] i_wdata,
    output logic        o_misalign,
    output logic [7:0]  o_wstrb,
    output logic [63:0] o_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [2:0]  i_ld_off,
    input  logic [63:0] i_rdata,
    output logic [63:0] o_rdata
);

    logic [63:0] w_rsh;
    logic        w_sgn;

    always_comb begin
        case (i_st_funct3[1:0])
            2'd0:    o_misalign = 1'b0;
            2'd1:    o_misalign = i_st_off[0];
            2'd2:    o_misalign = |i_st_off[1:0];
            default: o_misalign = |i_st_off;
        endcase
        if (i_st_funct3 == F3_BAD)
            o_misalign = 1'b1;
    end

    assign o_wstrb = size_mask(i_st_funct3[1:0]) << i_st_off;
    assign o_wdata = i_wdata << {i_st_off, 3'b000};

    assign w_rsh = i_rdata >> {i_ld_off, 3'b000};
    assign w_sgn = ~i_ld_funct3[2];

    always_comb begin
        case (i_ld_funct3[1:0])
            2'd0:    o_rdata = {{56{w_sgn & w_rsh[7]}},  w_rsh[7:0]};
            2'd1:    o_rdata = {{48{w_sgn & w_rsh[15]}}, w_rsh[15:0]};
            2'd2:    o_rdata = {{32{w_sgn & w_rsh[31]}}, w_rsh[31:0]};
            default: o_rdata = w_rsh;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one data-memory access per EX/MEM entry over a valid/ready
// bus, stalling EX/MEM via mem_idle while the access is pending or in flight.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_inst_load,
    input  logic              in_inst_store,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [63:0]       in_wdata,
    input  logic              wb_ready,
    output logic              mem_idle,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_wen,
    output logic [ADDR_W-1:0] req_addr,
    output logic [63:0]       req_wdata,
    output logic [7:0]        req_wstrb,
    input  logic              resp_valid,
    input  logic [63:0]       resp_rdata,
    output logic              resp_ready,
    output logic              out_valid,
    output logic [63:0]       out_rdata,
    output logic              out_misalign
);

    lsu_state_e        r_state, w_state_nxt;
    logic              r_req_wen;
    logic [ADDR_W-1:0] r_req_addr;
    logic [63:0]       r_req_wdata;
    logic [7:0]        r_req_wstrb;
    logic [2:0]        r_funct3;
    logic [2:0]        r_off;
    logic [63:0]       r_out_rdata;
    logic              r_out_misalign;

    logic              w_start;
    logic              w_misalign;
    logic [7:0]        w_wstrb;
    logic [63:0]       w_wdata;
    logic [63:0]       w_ld_data;

    assign w_start = (r_state == ST_IDLE) & in_valid & (in_inst_load | in_inst_store);

    lsu_align u_align (
        .i_st_funct3 (in_funct3),
        .i_st_off    (in_addr[2:0]),
        .i_wdata     (in_wdata),
        .o_misalign  (w_misalign),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata),
        .i_ld_funct3 (r_funct3),
        .i_ld_off    (r_off),
        .i_rdata     (resp_rdata),
        .o_rdata     (w_ld_data)
    );

    // A misaligned entry faults straight to DONE without touching the bus, so EX/MEM
    // is not held for it: mem_idle only drops for starts that will issue a request.
    always_comb begin
        w_state_nxt = r_state;
        mem_idle    = 1'b1;
        req_valid   = 1'b0;
        resp_ready  = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = w_misalign ? ST_DONE : ST_REQ;
                    mem_idle    = w_misalign;
                end
            end
            ST_REQ: begin
                mem_idle  = 1'b0;
                req_valid = 1'b1;
                if (req_ready)
                    w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                mem_idle   = 1'b0;
                resp_ready = 1'b1;
                if (resp_valid)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (wb_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_req_wen      <= 1'b0;
            r_req_addr     <= '0;
            r_req_wdata    <= '0;
            r_req_wstrb    <= '0;
            r_funct3       <= '0;
            r_off          <= '0;
            r_out_rdata    <= '0;
            r_out_misalign <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_out_misalign <= w_misalign;
                r_out_rdata    <= '0;
                if (!w_misalign) begin
                    r_req_wen   <= in_inst_store;
                    r_req_addr  <= {in_addr[ADDR_W-1:3], 3'b000};
                    r_req_wstrb <= in_inst_store ? w_wstrb : 8'h00;
                    r_req_wdata <= in_inst_store ? w_wdata : 64'h0;
                    r_funct3    <= in_funct3;
                    r_off       <= in_addr[2:0];
                end
            end
            if (r_state == ST_RESP && resp_valid)
                r_out_rdata <= r_req_wen ? 64'h0 : w_ld_data;
        end
    end

    assign req_wen      = r_req_wen;
    assign req_addr     = r_req_addr;
    assign req_wdata    = r_req_wdata;
    assign req_wstrb    = r_req_wstrb;
    assign out_rdata    = r_out_rdata;
    assign out_misalign = r_out_misalign;

endmodule
